// File: rtl/lsu_pkg.sv
// Shared types and constants for the memory-stage load/store unit.
package lsu_pkg;

   typedef enum logic [2:0] {
      F3Lb  = 3'b000,
      F3Lh  = 3'b001,
      F3Lw  = 3'b010,
      F3Lbu = 3'b100,
      F3Lhu = 3'b101
   } funct3_e;

   typedef enum logic [0:0] {
      StIdle,
      StWait
   } state_e;

   typedef enum logic [1:0] {
      SizeByte,
      SizeHalf,
      SizeWord
   } size_e;

   localparam logic [1:0] ResultSrcAlu = 2'd0;
   localparam logic [1:0] ResultSrcMem = 2'd1;
   localparam logic [1:0] ResultSrcPc4 = 2'd2;

   localparam int unsigned WaitCntWidth = 3;

   // Undefined funct3 encodings fall back to word access.
   function automatic size_e access_size(logic [2:0] funct3);
      case (funct3)
         F3Lb, F3Lbu: access_size = SizeByte;
         F3Lh, F3Lhu: access_size = SizeHalf;
         default:     access_size = SizeWord;
      endcase
   endfunction

endpackage

// File: rtl/stage_memory_lsu_if.sv
// Execute-to-memory stage bundle; master is the execute side, slave is the LSU.
interface stage_memory_lsu_if;
   logic        execute_valid;
   logic [4:0]  execute_rd;
   logic        execute_regfile_wr_enable;
   logic [31:0] execute_alu_result;
   logic [31:0] execute_instr_addr_plus;
   logic [1:0]  execute_result_src;
   logic        execute_datamem_rd_enable;
   logic        execute_datamem_wr_enable;
   logic [2:0]  execute_funct3;
   logic [31:0] execute_wr_datamem_data;

   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic        mem_regfile_wr_enable;
   logic [31:0] mem_alu_result;
   logic [31:0] mem_instr_addr_plus;
   logic [1:0]  mem_result_src;
   logic [31:0] mem_rd_datamem_data;
   logic        mem_valid;
   logic        mem_misaligned;

   modport master (
      output execute_valid, execute_rd, execute_regfile_wr_enable, execute_alu_result,
             execute_instr_addr_plus, execute_result_src, execute_datamem_rd_enable,
             execute_datamem_wr_enable, execute_funct3, execute_wr_datamem_data,
      input  mem_ready, mem_rd, mem_regfile_wr_enable, mem_alu_result, mem_instr_addr_plus,
             mem_result_src, mem_rd_datamem_data, mem_valid, mem_misaligned
   );

   modport slave (
      input  execute_valid, execute_rd, execute_regfile_wr_enable, execute_alu_result,
             execute_instr_addr_plus, execute_result_src, execute_datamem_rd_enable,
             execute_datamem_wr_enable, execute_funct3, execute_wr_datamem_data,
      output mem_ready, mem_rd, mem_regfile_wr_enable, mem_alu_result, mem_instr_addr_plus,
             mem_result_src, mem_rd_datamem_data, mem_valid, mem_misaligned
   );
endinterface

// File: rtl/datamem_bank.sv
// Four byte-lane data arrays sharing one address: synchronous masked write, async read.
module datamem_bank #(
   parameter int unsigned DEPTH_BYTES = 1024
) (
   input  logic                           clk,
   input  logic [$clog2(DEPTH_BYTES)-3:0] addr,
   input  logic [3:0]                     wr_be,
   input  logic [31:0]                    wr_data,
   output logic [31:0]                    rd_data
);

   localparam int unsigned Words = DEPTH_BYTES / 4;

   for (genvar g = 0; g < 4; g++) begin : g_lane
      logic [7:0] mem [Words];

      always_ff @(posedge clk) begin
         if (wr_be[g]) begin
            mem[addr] <= wr_data[8*g +: 8];
         end
      end

      assign rd_data[8*g +: 8] = mem[addr];
   end

endmodule

// File: rtl/stage_memory_lsu.sv
// Memory pipeline stage: passes execute results through and performs loads/stores
// against a local data memory with a configurable number of wait states.
module stage_memory_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES = 1024,
   parameter int unsigned WAIT_STATES = 1
) (
   input logic               clk,
   input logic               rst,
   stage_memory_lsu_if.slave bus
);

   localparam int unsigned AddrWidth = $clog2(DEPTH_BYTES);
   localparam bit HasWait = (WAIT_STATES != 0);
   localparam logic [WaitCntWidth-1:0] LastWait =
      HasWait ? WaitCntWidth'(WAIT_STATES - 1) : '0;

   state_e                  state_q, state_d;
   logic [WaitCntWidth-1:0] cnt_q, cnt_d;
   logic                    complete;

   logic                 is_store, is_load, is_mem, misaligned;
   logic [AddrWidth-1:0] addr;
   logic [1:0]           lane;
   size_e                size;
   logic [3:0]           be, be_commit;
   logic [31:0]          wr_data, rd_word, shifted, load_data;

   // Memory-op decode; both enables high is handled as a store.
   always_comb begin
      is_store = bus.execute_datamem_wr_enable;
      is_load  = bus.execute_datamem_rd_enable & ~bus.execute_datamem_wr_enable;
      is_mem   = is_store | is_load;
      addr     = bus.execute_alu_result[AddrWidth-1:0];
      lane     = addr[1:0];
      size     = access_size(bus.execute_funct3);
      misaligned = is_mem && (((size == SizeHalf) && addr[0]) ||
                              ((size == SizeWord) && (addr[1:0] != 2'b00)));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (bus.execute_valid && is_mem && HasWait) begin
               state_d = StWait;
               cnt_d   = '0;
            end
         end
         StWait: begin
            if (cnt_q == LastWait) state_d = StIdle;
            else                   cnt_d   = cnt_q + 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      bus.mem_ready = 1'b0;
      complete      = 1'b0;
      case (state_q)
         StIdle: begin
            bus.mem_ready = 1'b1;
            complete      = bus.execute_valid && (!is_mem || !HasWait);
         end
         StWait:  complete = (cnt_q == LastWait);
         default: ;
      endcase
   end

   always_comb begin
      case (size)
         SizeByte: begin
            be      = 4'b0001 << lane;
            wr_data = {4{bus.execute_wr_datamem_data[7:0]}};
         end
         SizeHalf: begin
            be      = 4'b0011 << {lane[1], 1'b0};
            wr_data = {2{bus.execute_wr_datamem_data[15:0]}};
         end
         default: begin
            be      = 4'b1111;
            wr_data = bus.execute_wr_datamem_data;
         end
      endcase
      be_commit = (complete && is_store && !misaligned) ? be : 4'b0000;
   end

   datamem_bank #(
      .DEPTH_BYTES(DEPTH_BYTES)
   ) u_bank (
      .clk    (clk),
      .addr   (addr[AddrWidth-1:2]),
      .wr_be  (be_commit),
      .wr_data(wr_data),
      .rd_data(rd_word)
   );

   // funct3[2] marks the unsigned load variants.
   always_comb begin
      shifted = rd_word >> {lane, 3'b000};
      case (size)
         SizeByte: load_data = {{24{~bus.execute_funct3[2] & shifted[7]}}, shifted[7:0]};
         SizeHalf: load_data = {{16{~bus.execute_funct3[2] & shifted[15]}}, shifted[15:0]};
         default:  load_data = shifted;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.mem_valid             <= 1'b0;
         bus.mem_misaligned        <= 1'b0;
         bus.mem_rd                <= '0;
         bus.mem_regfile_wr_enable <= 1'b0;
         bus.mem_alu_result        <= '0;
         bus.mem_instr_addr_plus   <= '0;
         bus.mem_result_src        <= '0;
         bus.mem_rd_datamem_data   <= '0;
      end else begin
         bus.mem_valid <= complete;
         if (complete) begin
            bus.mem_misaligned        <= misaligned;
            bus.mem_rd                <= bus.execute_rd;
            bus.mem_regfile_wr_enable <= bus.execute_regfile_wr_enable & ~misaligned;
            bus.mem_alu_result        <= bus.execute_alu_result;
            bus.mem_instr_addr_plus   <= bus.execute_instr_addr_plus;
            bus.mem_result_src        <= bus.execute_result_src;
            bus.mem_rd_datamem_data   <= (is_load && !misaligned) ? load_data : 32'd0;
         end
      end
   end

endmodule

// File: tb/tb_stage_memory_lsu.sv
// Directed bench: three LSU instances (no wait / 2 waits + 128 B / 3 waits) share one stimulus
// bus; sel picks which instance sees execute_valid and which outputs are observed.
module tb_stage_memory_lsu;
   import lsu_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned sel = 0;
   logic        ev = 1'b0, ld = 1'b0, st = 1'b0, rf_we = 1'b0;
   logic [2:0]  f3 = '0;
   logic [4:0]  rd = '0;
   logic [1:0]  src = '0;
   logic [31:0] alu = '0, wdat = '0, pc4 = '0;

   logic        o_ready, o_valid, o_mis, o_rf;
   logic [31:0] o_data, o_alu, o_pc4;
   logic [4:0]  o_rd;
   logic [1:0]  o_src;

   int n_checks = 0;
   int n_pass = 0;
   int lat, lows;

   stage_memory_lsu_if if_w0 ();
   stage_memory_lsu_if if_w2 ();
   stage_memory_lsu_if if_w3 ();

   assign if_w0.execute_valid = ev && (sel == 0);
   assign if_w2.execute_valid = ev && (sel == 1);
   assign if_w3.execute_valid = ev && (sel == 2);

   for (genvar k = 0; k < 3; k++) begin : g_drv
      if (k == 0) begin : g_a
         assign if_w0.execute_rd = rd;                assign if_w0.execute_regfile_wr_enable = rf_we;
         assign if_w0.execute_alu_result = alu;       assign if_w0.execute_instr_addr_plus = pc4;
         assign if_w0.execute_result_src = src;       assign if_w0.execute_datamem_rd_enable = ld;
         assign if_w0.execute_datamem_wr_enable = st; assign if_w0.execute_funct3 = f3;
         assign if_w0.execute_wr_datamem_data = wdat;
      end else if (k == 1) begin : g_b
         assign if_w2.execute_rd = rd;                assign if_w2.execute_regfile_wr_enable = rf_we;
         assign if_w2.execute_alu_result = alu;       assign if_w2.execute_instr_addr_plus = pc4;
         assign if_w2.execute_result_src = src;       assign if_w2.execute_datamem_rd_enable = ld;
         assign if_w2.execute_datamem_wr_enable = st; assign if_w2.execute_funct3 = f3;
         assign if_w2.execute_wr_datamem_data = wdat;
      end else begin : g_c
         assign if_w3.execute_rd = rd;                assign if_w3.execute_regfile_wr_enable = rf_we;
         assign if_w3.execute_alu_result = alu;       assign if_w3.execute_instr_addr_plus = pc4;
         assign if_w3.execute_result_src = src;       assign if_w3.execute_datamem_rd_enable = ld;
         assign if_w3.execute_datamem_wr_enable = st; assign if_w3.execute_funct3 = f3;
         assign if_w3.execute_wr_datamem_data = wdat;
      end
   end

   always_comb begin
      case (sel)
         1: begin
            o_ready = if_w2.mem_ready; o_valid = if_w2.mem_valid; o_mis = if_w2.mem_misaligned;
            o_rf = if_w2.mem_regfile_wr_enable; o_data = if_w2.mem_rd_datamem_data;
            o_alu = if_w2.mem_alu_result; o_pc4 = if_w2.mem_instr_addr_plus;
            o_rd = if_w2.mem_rd; o_src = if_w2.mem_result_src;
         end
         2: begin
            o_ready = if_w3.mem_ready; o_valid = if_w3.mem_valid; o_mis = if_w3.mem_misaligned;
            o_rf = if_w3.mem_regfile_wr_enable; o_data = if_w3.mem_rd_datamem_data;
            o_alu = if_w3.mem_alu_result; o_pc4 = if_w3.mem_instr_addr_plus;
            o_rd = if_w3.mem_rd; o_src = if_w3.mem_result_src;
         end
         default: begin
            o_ready = if_w0.mem_ready; o_valid = if_w0.mem_valid; o_mis = if_w0.mem_misaligned;
            o_rf = if_w0.mem_regfile_wr_enable; o_data = if_w0.mem_rd_datamem_data;
            o_alu = if_w0.mem_alu_result; o_pc4 = if_w0.mem_instr_addr_plus;
            o_rd = if_w0.mem_rd; o_src = if_w0.mem_result_src;
         end
      endcase
   end

   stage_memory_lsu #(.DEPTH_BYTES(1024), .WAIT_STATES(0)) u_w0 (.clk(clk), .rst(rst), .bus(if_w0));
   stage_memory_lsu #(.DEPTH_BYTES(128),  .WAIT_STATES(2)) u_w2 (.clk(clk), .rst(rst), .bus(if_w2));
   stage_memory_lsu #(.DEPTH_BYTES(1024), .WAIT_STATES(3)) u_w3 (.clk(clk), .rst(rst), .bus(if_w3));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) n_pass++;
      else $error("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Called just after a rising edge; holds the instruction until mem_valid is seen.
   task automatic issue(input logic [2:0] t_f3, input logic t_ld, input logic t_st,
                        input logic [31:0] t_alu, input logic [31:0] t_wd,
                        output int t_lat, output int t_lows);
      f3 = t_f3; ld = t_ld; st = t_st; alu = t_alu; wdat = t_wd;
      rf_we = 1'b1; rd = 5'd7; pc4 = t_alu + 32'd4;
      src = t_ld ? ResultSrcMem : ResultSrcAlu;
      ev = 1'b1;
      t_lat = 0;
      t_lows = 0;
      while (t_lat < 20) begin
         @(posedge clk);
         #1;
         t_lat++;
         if (!o_ready) t_lows++;
         if (o_valid) break;
      end
      ev = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(o_ready), 32'd1);
      chk("rst_valid", 32'(o_valid), 32'd0);
      chk("rst_rf", 32'(o_rf), 32'd0);
      chk("rst_data", o_data, 32'd0);
      sel = 1;
      #1;
      chk("rst_mis_w2", 32'(o_mis), 32'd0);
      chk("rst_alu_w2", o_alu, 32'd0);
      sel = 0;
      rst = 1'b0;
      idle_cycle();
      chk("idle_novalid", 32'(o_valid), 32'd0);

      // No wait states: ALU op, SW then LW back-to-back
      issue(3'b000, 1'b0, 1'b0, 32'h0000_1234, 32'h0, lat, lows);
      chk("w0_alu_lat", 32'(lat), 32'd1);
      chk("w0_alu_res", o_alu, 32'h0000_1234);
      chk("w0_alu_pc4", o_pc4, 32'h0000_1238);
      chk("w0_alu_rd", 32'(o_rd), 32'd7);
      issue(F3Lw, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat, lows);
      chk("w0_sw_lat", 32'(lat), 32'd1);
      chk("w0_sw_lows", 32'(lows), 32'd0);
      issue(F3Lw, 1'b1, 1'b0, 32'h10, 32'h0, lat, lows);
      chk("w0_lw_lat", 32'(lat), 32'd1);
      chk("w0_lw_lows", 32'(lows), 32'd0);
      chk("w0_lw_data", o_data, 32'hDEAD_BEEF);
      chk("w0_lw_src", 32'(o_src), 32'(ResultSrcMem));
      idle_cycle();
      chk("w0_pulse_once", 32'(o_valid), 32'd0);
      chk("w0_hold_data", o_data, 32'hDEAD_BEEF);

      // Misalignment
      issue(F3Lh, 1'b1, 1'b0, 32'h03, 32'h0, lat, lows);
      chk("w0_lh_mis", 32'(o_mis), 32'd1);
      chk("w0_lh_rf", 32'(o_rf), 32'd0);
      chk("w0_lh_data", o_data, 32'd0);
      issue(F3Lw, 1'b0, 1'b1, 32'h00, 32'h1111_1111, lat, lows);
      chk("w0_sw0_mis", 32'(o_mis), 32'd0);
      issue(F3Lw, 1'b0, 1'b1, 32'h04, 32'h2222_2222, lat, lows);
      issue(F3Lw, 1'b0, 1'b1, 32'h02, 32'h9999_9999, lat, lows);
      chk("w0_sw2_mis", 32'(o_mis), 32'd1);
      issue(F3Lw, 1'b1, 1'b0, 32'h00, 32'h0, lat, lows);
      chk("w0_mem0_keep", o_data, 32'h1111_1111);
      issue(F3Lw, 1'b1, 1'b0, 32'h04, 32'h0, lat, lows);
      chk("w0_mem4_keep", o_data, 32'h2222_2222);

      // ALU, SH, LHU back-to-back
      issue(3'b000, 1'b0, 1'b0, 32'hCAFE_0001, 32'h0, lat, lows);
      chk("w0_alu2_lat", 32'(lat), 32'd1);
      chk("w0_alu2_res", o_alu, 32'hCAFE_0001);
      issue(F3Lh, 1'b0, 1'b1, 32'h0A, 32'h1234_BEEF, lat, lows);
      issue(F3Lhu, 1'b1, 1'b0, 32'h0A, 32'h0, lat, lows);
      chk("w0_lhu_data", o_data, 32'h0000_BEEF);
      issue(F3Lh, 1'b1, 1'b0, 32'h0A, 32'h0, lat, lows);
      chk("w0_lh_sext", o_data, 32'hFFFF_BEEF);

      // Two wait states, 128-byte memory
      sel = 1;
      #1;
      issue(F3Lb, 1'b0, 1'b1, 32'h21, 32'h1234_5680, lat, lows);
      chk("w2_sb_lat", 32'(lat), 32'd3);
      chk("w2_sb_lows", 32'(lows), 32'd2);
      issue(F3Lb, 1'b1, 1'b0, 32'h21, 32'h0, lat, lows);
      chk("w2_lb_lat", 32'(lat), 32'd3);
      chk("w2_lb_lows", 32'(lows), 32'd2);
      chk("w2_lb_data", o_data, 32'hFFFF_FF80);
      issue(F3Lbu, 1'b1, 1'b0, 32'h21, 32'h0, lat, lows);
      chk("w2_lbu_data", o_data, 32'h0000_0080);
      issue(3'b000, 1'b0, 1'b0, 32'h55, 32'h0, lat, lows);
      chk("w2_alu_lat", 32'(lat), 32'd1);
      issue(F3Lw, 1'b0, 1'b1, 32'h84, 32'h1234_5678, lat, lows);
      issue(F3Lw, 1'b1, 1'b0, 32'h04, 32'h0, lat, lows);
      chk("w2_wrap_data", o_data, 32'h1234_5678);
      chk("w2_wrap_alu", o_alu, 32'h0000_0004);

      // Three wait states: reset mid-store must not commit
      sel = 2;
      #1;
      issue(F3Lw, 1'b0, 1'b1, 32'h40, 32'h1122_3344, lat, lows);
      chk("w3_sw_lat", 32'(lat), 32'd4);
      chk("w3_sw_alu", o_alu, 32'h0000_0040);
      f3 = F3Lw; ld = 1'b0; st = 1'b1; alu = 32'h40; wdat = 32'hAAAA_AAAA; ev = 1'b1;
      idle_cycle();
      chk("w3_wait_ready", 32'(o_ready), 32'd0);
      idle_cycle();
      rst = 1'b1;
      #1;
      chk("w3_rst_ready", 32'(o_ready), 32'd1);
      chk("w3_rst_valid", 32'(o_valid), 32'd0);
      chk("w3_rst_alu", o_alu, 32'd0);
      ev = 1'b0;
      idle_cycle();
      idle_cycle();
      rst = 1'b0;
      idle_cycle();
      issue(F3Lw, 1'b1, 1'b0, 32'h40, 32'h0, lat, lows);
      chk("w3_lw_lat", 32'(lat), 32'd4);
      chk("w3_lw_keep", o_data, 32'h1122_3344);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
